// File: rtl/e_min_tracker_pkg.sv
// Shared types and constants for the minimum-energy tracker.
// State encoding and the all-ones energy sentinel live here.
package e_min_tracker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int E_WIDTH_DEF = 20;
  localparam logic [E_WIDTH_DEF-1:0] E_MAX = '1;

endpackage

// File: rtl/e_min_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// clr and inc together load the value one.
module e_min_tracker_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 sat_hit
);

  logic [CNT_WIDTH-1:0] base;
  logic [CNT_WIDTH-1:0] nxt;

  always_comb begin
    base = clr ? '0 : cnt;
    nxt  = base;
    if (inc && !(&base)) begin
      nxt = base + 1'b1;
    end
  end

  // Flags the edge on which the counter sits at all-ones after an increment.
  assign sat_hit = inc && (&nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/e_min_tracker.sv
// Tracks minimum energy, first best sequence, tie count and beat total
// over one search run; result handed off through valid/ready.
module e_min_tracker
  import e_min_tracker_pkg::*;
#(
  parameter int SEQ_WIDTH = 8,
  parameter int E_WIDTH   = E_WIDTH_DEF,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [SEQ_WIDTH-1:0] i_seq,
  input  logic [E_WIDTH-1:0]   i_e,
  input  logic                 i_valid,
  input  logic                 i_last,
  output logic                 o_busy,
  output logic [SEQ_WIDTH-1:0] o_best_seq,
  output logic [E_WIDTH-1:0]   o_best_e,
  output logic [CNT_WIDTH-1:0] o_best_cnt,
  output logic [CNT_WIDTH-1:0] o_total,
  output logic                 o_sat,
  output logic                 o_res_valid,
  input  logic                 i_res_ready
);

  localparam logic [E_WIDTH-1:0] E_ONES = '1;

  state_t state;
  state_t state_nxt;

  logic clr;
  logic beat;
  logic lt;
  logic eq;
  logic bc_clr;
  logic bc_inc;
  logic tot_hit;
  logic bc_hit;

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    beat      = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          clr       = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // A restart takes priority over any beat in the same cycle.
        if (i_start) begin
          clr = 1'b1;
        end else if (i_valid) begin
          beat = 1'b1;
          if (i_last) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lt = i_e < o_best_e;
  assign eq = i_e == o_best_e;

  // A new minimum restarts the tie count at one.
  assign bc_clr = clr | (beat & lt);
  assign bc_inc = beat & (lt | eq);

  e_min_tracker_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_total (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .inc    (beat),
    .cnt    (o_total),
    .sat_hit(tot_hit)
  );

  e_min_tracker_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_best_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (bc_clr),
    .inc    (bc_inc),
    .cnt    (o_best_cnt),
    .sat_hit(bc_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      o_busy      <= 1'b0;
      o_res_valid <= 1'b0;
      o_best_e    <= E_ONES;
      o_best_seq  <= '0;
      o_sat       <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_busy      <= (state_nxt == RUN);
      o_res_valid <= (state_nxt == HOLD);
      if (clr) begin
        o_best_e   <= E_ONES;
        o_best_seq <= '0;
        o_sat      <= 1'b0;
      end else if (beat) begin
        if (lt) begin
          o_best_e   <= i_e;
          o_best_seq <= i_seq;
        end
        if (tot_hit || bc_hit) begin
          o_sat <= 1'b1;
        end
      end
    end
  end

endmodule
